// File: rtl/prog3_pkg.sv
// Shared constants, FSM state type and the 4-window matcher for the
// pattern-search engine.
package prog3_pkg;

  localparam logic [7:0] STR_BASE = 8'd0;
  localparam int         STR_LEN  = 32;
  localparam logic [7:0] PAT_ADDR = 8'd32;
  localparam logic [7:0] CTB_ADDR = 8'd33;
  localparam logic [7:0] CTO_ADDR = 8'd34;
  localparam logic [7:0] CTS_ADDR = 8'd35;

  typedef enum logic [2:0] {
    IDLE,
    PAT,
    SCAN,
    WR,
    DONE
  } state_t;

  // Counts the four 5-bit windows b[k+4:k], k = 0..3, that equal p.
  // Byte-crossing windows reuse this on {prev[3:0], cur[7:4]}.
  function automatic logic [2:0] count4(input logic [7:0] b, input logic [4:0] p);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < 4; k++) begin
      if (b[k +: 5] == p) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read, synchronous write, never reset
// so its contents can be preloaded and survive an engine reset.
module data_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] core [256];

  assign rdata = core[addr];

  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

endmodule

// File: rtl/top_level_pattern_search.sv
// Scans a 32-byte message in dm1 for a 5-bit pattern and writes the
// in-byte, per-byte and total match counts back to memory.
module top_level_pattern_search
  import prog3_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  state_t     state, next_state;
  logic [4:0] index;
  logic [7:0] prev;
  logic [4:0] pat;
  logic [7:0] ctb, cto, cts;

  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0] in_cnt, cross_cnt;

  data_mem dm1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign in_cnt    = count4(mem_rdata, pat);
  assign cross_cnt = (index != 5'd0) ? count4({prev[3:0], mem_rdata[7:4]}, pat) : 3'd0;

  // done is registered from next_state so it rises with the DONE state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state == DONE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!start) next_state = PAT;
      PAT:     next_state = SCAN;
      SCAN:    if (index == 5'(STR_LEN - 1)) next_state = WR;
      WR:      if (index == 5'd2) next_state = DONE;
      DONE:    if (start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = STR_BASE + {3'b000, index};
    mem_wdata = ctb;
    case (state)
      PAT: mem_addr = PAT_ADDR;
      WR: begin
        mem_we = 1'b1;
        case (index)
          5'd0: begin mem_addr = CTB_ADDR; mem_wdata = ctb; end
          5'd1: begin mem_addr = CTO_ADDR; mem_wdata = cto; end
          default: begin mem_addr = CTS_ADDR; mem_wdata = cts; end
        endcase
      end
      default: ;
    endcase
  end

  // index walks the message in SCAN, then sequences the three result writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index <= '0;
      prev  <= '0;
      pat   <= '0;
      ctb   <= '0;
      cto   <= '0;
      cts   <= '0;
    end else begin
      case (state)
        IDLE: begin
          index <= '0;
          ctb   <= '0;
          cto   <= '0;
          cts   <= '0;
        end
        PAT: begin
          pat   <= mem_rdata[7:3];
          index <= '0;
        end
        SCAN: begin
          ctb   <= ctb + {5'b00000, in_cnt};
          cto   <= cto + {7'b0000000, (in_cnt != 3'd0)};
          cts   <= cts + {5'b00000, in_cnt} + {5'b00000, cross_cnt};
          prev  <= mem_rdata;
          index <= index + 5'd1;
        end
        WR:      index <= index + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level_pattern_search.sv
// Directed self-checking bench for top_level_pattern_search: counts,
// start-to-done latency and mid-scan reset behaviour.
module tb_top_level_pattern_search;
  import prog3_pkg::*;

  logic clk;
  logic reset;
  logic start;
  logic done;

  int checks   = 0;
  int failures = 0;

  top_level_pattern_search dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Preload message, pattern byte and poison the result slots.
  task automatic applyStimulus(input logic [7:0] fill, input logic [7:0] byte0,
                               input logic [7:0] pat_byte);
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = fill;
    dut.dm1.core[0]  = byte0;
    dut.dm1.core[32] = pat_byte;
    dut.dm1.core[33] = 8'hEE;
    dut.dm1.core[34] = 8'hEE;
    dut.dm1.core[35] = 8'hEE;
  endtask

  // Drops start, measures edges to done, checks results, then releases.
  task automatic checkOutput(input string tag, input int exp_ctb,
                             input int exp_cto, input int exp_cts);
    int edges;
    edges = 0;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_latency"}, edges, 37);
    check({tag, "_ctb"}, int'(dut.dm1.core[33]), exp_ctb);
    check({tag, "_cto"}, int'(dut.dm1.core[34]), exp_cto);
    check({tag, "_cts"}, int'(dut.dm1.core[35]), exp_cts);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, int'(done), 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, int'(done), 0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    #12;
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dut.state === IDLE), 1);
    check("rst_index", int'(dut.index), 0);
    check("rst_cts", int'(dut.cts), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(8'h00, 8'h00, 8'h00);
    checkOutput("zeros_p00000", 128, 32, 252);

    applyStimulus(8'hFF, 8'hFF, 8'hF8);
    checkOutput("ones_p11111", 128, 32, 252);

    applyStimulus(8'h55, 8'h55, 8'hAF);
    checkOutput("alt55_p10101", 64, 32, 126);

    applyStimulus(8'h00, 8'hF8, 8'hFB);
    checkOutput("single_f8", 1, 1, 1);

    applyStimulus(8'h00, 8'h00, 8'hF8);
    checkOutput("zeros_p11111", 0, 0, 0);

    // Mid-scan reset, then a full rerun on the same memory.
    applyStimulus(8'hFF, 8'hFF, 8'hF8);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_done", int'(done), 0);
    check("midrst_state", int'(dut.state === IDLE), 1);
    check("midrst_mem0", int'(dut.dm1.core[0]), 8'hFF);
    check("midrst_pat", int'(dut.dm1.core[32]), 8'hF8);
    start = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("after_rst", 128, 32, 252);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
